// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/writeback control FSM
// driving IR load, PC increment and a per-instruction retire pulse.
module instruction_sequencer #(
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       halt_req,
  input  logic       mem_ready,
  input  logic [3:0] opcode,
  output logic       mem_req,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       update_count,
  output logic       halted,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_t;

  state_t     state;
  logic [3:0] op_q;
  logic [1:0] exec_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      exec_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (halt_req)  state <= HALTED;
          else if (run)  state <= FETCH;
        end
        FETCH: begin
          if (mem_ready) begin
            op_q  <= opcode;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (op_q == HALT_OPCODE) begin
            state <= WRITEBACK;
          end else begin
            exec_cnt <= op_q[1:0];
            state    <= EXECUTE;
          end
        end
        EXECUTE: begin
          if (exec_cnt == 2'd0) state <= WRITEBACK;
          else                  exec_cnt <= exec_cnt - 2'd1;
        end
        WRITEBACK: begin
          if (op_q == HALT_OPCODE || halt_req) state <= HALTED;
          else if (run)                         state <= FETCH;
          else                                  state <= IDLE;
        end
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode from the state register; only the fetch strobes also see mem_ready.
  always_comb begin
    state_out    = state;
    mem_req      = (state == FETCH);
    ir_load      = (state == FETCH) && mem_ready;
    pc_inc       = (state == FETCH) && mem_ready;
    update_count = (state == WRITEBACK);
    halted       = (state == HALTED);
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: per-cycle expected outputs are queued
// as each cycle's stimulus is driven and checked mid-cycle against the DUT.
module tb_instruction_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       halt_req;
  logic       mem_ready;
  logic [3:0] opcode;
  logic       mem_req;
  logic       ir_load;
  logic       pc_inc;
  logic       update_count;
  logic       halted;
  logic [2:0] state_out;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned uc_seen  = 0;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];

  instruction_sequencer #(.HALT_OPCODE(4'hF)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .halt_req     (halt_req),
    .mem_ready    (mem_ready),
    .opcode       (opcode),
    .mem_req      (mem_req),
    .ir_load      (ir_load),
    .pc_inc       (pc_inc),
    .update_count (update_count),
    .halted       (halted),
    .state_out    (state_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (update_count === 1'b1) uc_seen++;

  function automatic logic [7:0] pack(input logic [2:0] st, input logic mq, il, pi, uc, hl);
    return {st, mq, il, pi, uc, hl};
  endfunction

  function automatic logic [7:0] observed();
    return {state_out, mem_req, ir_load, pc_inc, update_count, halted};
  endfunction

  task automatic check_now(input logic [7:0] exp, input string tag);
    logic [7:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, queue the expectation,
  // compare at the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input logic r, h, mr, input logic [3:0] op,
                     input logic [2:0] st, input logic mq, il, pi, uc, hl,
                     input string tag);
    exp_t e;
    run = r; halt_req = h; mem_ready = mr; opcode = op;
    e.v = pack(st, mq, il, pi, uc, hl);
    e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_now(e.v, e.tag);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1 check_now(8'h00, tag);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; halt_req = 1'b0; mem_ready = 1'b1; opcode = 4'h0;
    @(posedge clk); #1;
    check_now(8'h00, "reset_hold");
    @(posedge clk); #1;
    reset = 1'b0;

    // Back-to-back opcode 0 then opcode 3 with mem_ready held high
    cyc(1,0,1,4'h0, 3'd0,0,0,0,0,0, "a_idle");
    cyc(1,0,1,4'h0, 3'd1,1,1,1,0,0, "a_fetch0");
    cyc(1,0,1,4'h0, 3'd2,0,0,0,0,0, "a_decode0");
    cyc(1,0,1,4'h0, 3'd3,0,0,0,0,0, "a_exec0");
    cyc(1,0,1,4'h0, 3'd4,0,0,0,1,0, "a_wb0");
    cyc(1,0,1,4'h3, 3'd1,1,1,1,0,0, "a_fetch3");
    cyc(1,0,1,4'h0, 3'd2,0,0,0,0,0, "a_decode3");
    for (int unsigned i = 0; i < 4; i++)
      cyc(1,0,1,4'h0, 3'd3,0,0,0,0,0, $sformatf("a_exec3_%0d", i));
    cyc(1,0,1,4'h0, 3'd4,0,0,0,1,0, "a_wb3");

    // Memory wait states, then opcode 2 with run dropped mid-flight
    for (int unsigned i = 0; i < 3; i++)
      cyc(1,0,0,4'h2, 3'd1,1,0,0,0,0, $sformatf("b_wait_%0d", i));
    cyc(1,0,1,4'h2, 3'd1,1,1,1,0,0, "b_fetch2");
    cyc(0,0,1,4'h0, 3'd2,0,0,0,0,0, "b_decode2_norun");
    cyc(0,0,1,4'h0, 3'd3,0,0,0,0,0, "b_exec2_first");
    check_now(pack(3'd3,0,0,0,0,0), "b_exec2_second");
    pulse_reset("b_reset_mid_exec");

    // halt_req in WRITEBACK wins over run
    cyc(1,0,1,4'h0, 3'd0,0,0,0,0,0, "c_idle");
    cyc(1,0,1,4'h0, 3'd1,1,1,1,0,0, "c_fetch");
    cyc(1,0,1,4'h0, 3'd2,0,0,0,0,0, "c_decode");
    cyc(1,0,1,4'h0, 3'd3,0,0,0,0,0, "c_exec");
    cyc(1,1,1,4'h0, 3'd4,0,0,0,1,0, "c_wb_halt");
    cyc(1,0,1,4'h0, 3'd5,0,0,0,0,1, "c_halted0");
    cyc(1,0,1,4'h0, 3'd5,0,0,0,0,1, "c_halted1");
    pulse_reset("c_reset_halted");

    // HALT_OPCODE skips EXECUTE and parks in HALTED
    cyc(1,0,1,4'hF, 3'd0,0,0,0,0,0, "d_idle");
    cyc(1,0,1,4'hF, 3'd1,1,1,1,0,0, "d_fetchF");
    cyc(1,0,1,4'h0, 3'd2,0,0,0,0,0, "d_decodeF");
    cyc(1,0,1,4'h0, 3'd4,0,0,0,1,0, "d_wbF");
    cyc(1,0,1,4'h0, 3'd5,0,0,0,0,1, "d_halted0");
    cyc(1,0,1,4'h0, 3'd5,0,0,0,0,1, "d_halted1");
    pulse_reset("d_reset");

    // IDLE holds without run; halt_req has priority over run
    cyc(0,0,1,4'h0, 3'd0,0,0,0,0,0, "e_idle0");
    cyc(0,0,1,4'h0, 3'd0,0,0,0,0,0, "e_idle1");
    cyc(1,1,1,4'h0, 3'd0,0,0,0,0,0, "e_idle_halt");
    cyc(1,0,1,4'h0, 3'd5,0,0,0,0,1, "e_halted");

    checks++;
    assert (uc_seen == 4) else begin
      failures++;
      $error("FAIL retire_pulses observed=%0d expected=%0d", uc_seen, 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
